alu_cmd_seq: RTL and testbench
==============================

Name: alu_cmd_seq

Overview:
- Byte-stream command sequencer directly upstream of ALU_16bit.
- Assembles 5-byte command frames from a byte source (UART RX side): function code, operand A, operand B.
- Drives A, B and ALU_FUN into the ALU and waits out the ALU's registered-output latency.
- Captures ALU_OUT plus the four flags and returns them as a 3-byte response over a valid/ready byte interface (UART TX side).

Parameters:
- ALU_LAT, 1, clock edges from operands/function being driven to ALU_OUT and flags valid (1..4).
- NOP_FUN, 4'hF, function code driven while idle; the ALU holds its outputs for this code.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- RX_DATA  in  8  incoming command byte.
- RX_VALID  in  1  one-cycle strobe, RX_DATA valid; no backpressure.
- TX_DATA  out  8  response byte.
- TX_VALID  out  1  response byte valid.
- TX_READY  in  1  consumer accepts TX_DATA when TX_VALID && TX_READY.
- ALU_A  out  16  operand A to ALU.
- ALU_B  out  16  operand B to ALU.
- ALU_FUN  out  4  function code to ALU.
- ALU_OUT  in  16  ALU result.
- ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG  in  1 each  ALU class flags.
- BUSY  out  1  high in every state except IDLE.
- FRAME_ERR  out  1  one-cycle pulse, frame rejected.
- OVERRUN  out  1  one-cycle pulse, RX byte dropped.

Behaviour:
- Reset while RST=0, asynchronous, from any state including mid-frame or mid-send:
  - State = IDLE.
  - ALU_A = 0, ALU_B = 0, ALU_FUN = NOP_FUN.
  - TX_DATA = 0, TX_VALID = 0, BUSY = 0, FRAME_ERR = 0, OVERRUN = 0.
  - Latency counter and result/flag capture registers cleared.
  - Partial frames are discarded.
- Frame format: FUN, A_lo, A_hi, B_lo, B_hi.
  - FUN[7:4] must be 0; otherwise pulse FRAME_ERR and stay in IDLE.
- State sequence: IDLE -> GET_A0 -> GET_A1 -> GET_B0 -> GET_B1 -> EXEC -> SEND0 -> SEND1 -> SEND2 -> IDLE.
  - Each GET_* state advances only on RX_VALID and latches its byte into an internal shadow register.
- ALU_A, ALU_B and ALU_FUN update only on entry to EXEC, all in the same cycle, from the shadow registers.
  - They hold through SEND2 and after it; ALU_FUN returns to NOP_FUN on return to IDLE.
- EXEC latency:
  - Counter loads ALU_LAT on entry to EXEC and decrements each cycle.
  - At count 0, capture ALU_OUT and the flags, then go to SEND0.
  - Frame-complete to first TX_VALID = ALU_LAT+1 cycles.
- Response bytes:
  - SEND0 = RES[7:0].
  - SEND1 = RES[15:8].
  - SEND2 = {4'b0, ARITH, LOGIC, CMP, SHIFT}.
- TX handshake:
  - TX_VALID is high throughout SEND*.
  - TX_DATA holds stable until TX_READY is sampled high; the state then advances on that edge.
  - Back-to-back bytes are allowed when TX_READY is held high.
- RX_VALID in EXEC or SEND*: the byte is dropped and OVERRUN pulses for one cycle; the state is unaffected.
- FUN = NOP_FUN is a legal frame. The response carries the ALU's held outputs, which equal the previous frame's result and flags.
- There is no inter-byte timeout: a partial frame waits indefinitely until reset.

Optional Feature:
- Macro: ALU_SHORT_FRAME_EN.
- Defined:
  - For FUN = 13 or 14 (shift operations), GET_A1 goes directly to EXEC.
  - ALU_B keeps its previous value.
  - The frame is 3 bytes.
- Undefined: every frame is 5 bytes, including shift commands.

Decomposition:
- Shared package alu_pkg:
  - 4-bit function code constants: ADD=0, SUB=1, MUL=2, DIV=3, AND=4, OR=5, NAND=6, NOR=7, XOR=8, XNOR=9, EQ=10, GT=11, LT=12, SHR=13, SHL=14, NOP=15.
  - Sequencer state enum.
  - Flag-byte bit positions.
- Single module; no sub-module needed. The response serializer stays inline as states SEND0..2.

Test Plan:
- ADD frame 00,04,00,03,00, TX_READY=1 -> ALU_FUN=0, A=4, B=3 for ALU_LAT cycles; TX bytes 07,00,08; BUSY falls after the third handshake.
- XNOR frame 09,07,00,06,00 -> TX FE,FF,04. GT frame 0B,07,00,06,00 -> TX 02,00,02.
- Backpressure: SUB frame 01,04,00,03,00, TX_READY low for 5 cycles at SEND1 -> TX_DATA stays 00 and TX_VALID stays high; then bytes 01,00,08.
- Overrun and error:
  - RX byte AA during SEND0 -> OVERRUN one-cycle pulse; response unchanged.
  - Frame starting 1F -> FRAME_ERR pulse; still IDLE; next valid frame processes normally.
- Reset mid-frame: assert RST low after A_hi of an ADD frame -> all outputs at reset values immediately. After release, a full SHL frame 0E,07,00,00,00 -> TX 0E,00,01.
- With ALU_SHORT_FRAME_EN: SHR frame 0D,07,00 -> TX 03,00,01; ALU_B unchanged from the prior frame.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU_16bit command sequencer: function codes,
// sequencer states and response flag-byte layout.
package alu_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned FUN_W  = 4;
  localparam int unsigned FLAG_W = 4;

  localparam logic [FUN_W-1:0] FUN_ADD  = 4'd0;
  localparam logic [FUN_W-1:0] FUN_SUB  = 4'd1;
  localparam logic [FUN_W-1:0] FUN_MUL  = 4'd2;
  localparam logic [FUN_W-1:0] FUN_DIV  = 4'd3;
  localparam logic [FUN_W-1:0] FUN_AND  = 4'd4;
  localparam logic [FUN_W-1:0] FUN_OR   = 4'd5;
  localparam logic [FUN_W-1:0] FUN_NAND = 4'd6;
  localparam logic [FUN_W-1:0] FUN_NOR  = 4'd7;
  localparam logic [FUN_W-1:0] FUN_XOR  = 4'd8;
  localparam logic [FUN_W-1:0] FUN_XNOR = 4'd9;
  localparam logic [FUN_W-1:0] FUN_EQ   = 4'd10;
  localparam logic [FUN_W-1:0] FUN_GT   = 4'd11;
  localparam logic [FUN_W-1:0] FUN_LT   = 4'd12;
  localparam logic [FUN_W-1:0] FUN_SHR  = 4'd13;
  localparam logic [FUN_W-1:0] FUN_SHL  = 4'd14;
  localparam logic [FUN_W-1:0] FUN_NOP  = 4'd15;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GET_A0,
    ST_GET_A1,
    ST_GET_B0,
    ST_GET_B1,
    ST_EXEC,
    ST_SEND0,
    ST_SEND1,
    ST_SEND2
  } seq_state_e;

  localparam int unsigned FLAG_SHIFT_BIT = 0;
  localparam int unsigned FLAG_CMP_BIT   = 1;
  localparam int unsigned FLAG_LOGIC_BIT = 2;
  localparam int unsigned FLAG_ARITH_BIT = 3;

  // Flags are held internally as {arith, logic, cmp, shift}.
  function automatic logic [BYTE_W-1:0] flag_byte(input logic [FLAG_W-1:0] fl);
    logic [BYTE_W-1:0] b;
    b = '0;
    b[FLAG_ARITH_BIT] = fl[3];
    b[FLAG_LOGIC_BIT] = fl[2];
    b[FLAG_CMP_BIT]   = fl[1];
    b[FLAG_SHIFT_BIT] = fl[0];
    return b;
  endfunction

  function automatic logic is_shift_fun(input logic [FUN_W-1:0] f);
    return (f == FUN_SHR) || (f == FUN_SHL);
  endfunction

endpackage

// File: rtl/alu_cmd_seq.sv
// Byte-stream command sequencer in front of ALU_16bit: 5-byte frames in, 3-byte response out.
// Define ALU_SHORT_FRAME_EN to accept 3-byte frames for shift commands.
module alu_cmd_seq
  import alu_pkg::*;
#(
  parameter int unsigned      ALU_LAT = 1,
  parameter logic [FUN_W-1:0] NOP_FUN = 4'hF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [BYTE_W-1:0] RX_DATA,
  input  logic              RX_VALID,
  output logic [BYTE_W-1:0] TX_DATA,
  output logic              TX_VALID,
  input  logic              TX_READY,
  output logic [DATA_W-1:0] ALU_A,
  output logic [DATA_W-1:0] ALU_B,
  output logic [FUN_W-1:0]  ALU_FUN,
  input  logic [DATA_W-1:0] ALU_OUT,
  input  logic              ARITH_FLAG,
  input  logic              LOGIC_FLAG,
  input  logic              CMP_FLAG,
  input  logic              SHIFT_FLAG,
  output logic              BUSY,
  output logic              FRAME_ERR,
  output logic              OVERRUN
);

  localparam int unsigned CNT_W = 3;

  seq_state_e        state_q, state_d;
  logic [FUN_W-1:0]  fun_q, fun_d;
  logic [DATA_W-1:0] a_sh_q, a_sh_d;
  logic [BYTE_W-1:0] b_lo_q, b_lo_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [FUN_W-1:0]  alu_fun_q, alu_fun_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              busy_q, busy_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      fun_q      <= '0;
      a_sh_q     <= '0;
      b_lo_q     <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_fun_q  <= NOP_FUN;
      cnt_q      <= '0;
      res_q      <= '0;
      flags_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fun_q      <= fun_d;
      a_sh_q     <= a_sh_d;
      b_lo_q     <= b_lo_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_fun_q  <= alu_fun_d;
      cnt_q      <= cnt_d;
      res_q      <= res_d;
      flags_q    <= flags_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fun_d      = fun_q;
    a_sh_d     = a_sh_q;
    b_lo_d     = b_lo_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_fun_d  = alu_fun_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    flags_d    = flags_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    ferr_d     = 1'b0;
    ovr_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (RX_VALID) begin
          if (RX_DATA[7:4] != 4'h0) begin
            ferr_d = 1'b1;
          end else begin
            fun_d   = RX_DATA[3:0];
            state_d = ST_GET_A0;
          end
        end
      end
      ST_GET_A0: begin
        if (RX_VALID) begin
          a_sh_d[7:0] = RX_DATA;
          state_d     = ST_GET_A1;
        end
      end
      ST_GET_A1: begin
        if (RX_VALID) begin
          a_sh_d[15:8] = RX_DATA;
          state_d      = ST_GET_B0;
`ifdef ALU_SHORT_FRAME_EN
          // Shift commands carry no B operand; ALU_B keeps its last value.
          if (is_shift_fun(fun_q)) begin
            alu_a_d   = {RX_DATA, a_sh_q[7:0]};
            alu_fun_d = fun_q;
            cnt_d     = CNT_W'(ALU_LAT);
            state_d   = ST_EXEC;
          end
`endif
        end
      end
      ST_GET_B0: begin
        if (RX_VALID) begin
          b_lo_d  = RX_DATA;
          state_d = ST_GET_B1;
        end
      end
      ST_GET_B1: begin
        if (RX_VALID) begin
          alu_a_d   = a_sh_q;
          alu_b_d   = {RX_DATA, b_lo_q};
          alu_fun_d = fun_q;
          cnt_d     = CNT_W'(ALU_LAT);
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        ovr_d = RX_VALID;
        if (cnt_q == '0) begin
          res_d      = ALU_OUT;
          flags_d    = {ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG};
          tx_data_d  = ALU_OUT[7:0];
          tx_valid_d = 1'b1;
          state_d    = ST_SEND0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SEND0: begin
        ovr_d = RX_VALID;
        if (TX_READY) begin
          tx_data_d = res_q[15:8];
          state_d   = ST_SEND1;
        end
      end
      ST_SEND1: begin
        ovr_d = RX_VALID;
        if (TX_READY) begin
          tx_data_d = flag_byte(flags_q);
          state_d   = ST_SEND2;
        end
      end
      ST_SEND2: begin
        ovr_d = RX_VALID;
        if (TX_READY) begin
          tx_valid_d = 1'b0;
          alu_fun_d  = NOP_FUN;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign TX_DATA   = tx_data_q;
  assign TX_VALID  = tx_valid_q;
  assign ALU_A     = alu_a_q;
  assign ALU_B     = alu_b_q;
  assign ALU_FUN   = alu_fun_q;
  assign BUSY      = busy_q;
  assign FRAME_ERR = ferr_q;
  assign OVERRUN   = ovr_q;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Bench for alu_cmd_seq: directed frames plus random frames against an ALU model
// and a frame-level response model. Honors ALU_SHORT_FRAME_EN when defined.
module tb_alu_cmd_seq;

  localparam int ALU_LAT = 1;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY;
  logic [15:0] ALU_A, ALU_B, ALU_OUT;
  logic [3:0]  ALU_FUN;
  logic        ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG;
  logic        BUSY, FRAME_ERR, OVERRUN;

  int n_vec = 0;
  int n_err = 0;

  logic [19:0] ref_prev;
  logic [15:0] last_b;

  alu_cmd_seq #(.ALU_LAT(ALU_LAT), .NOP_FUN(4'hF)) dut (
    .CLK(CLK), .RST(RST),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN),
    .ALU_OUT(ALU_OUT),
    .ARITH_FLAG(ARITH_FLAG), .LOGIC_FLAG(LOGIC_FLAG),
    .CMP_FLAG(CMP_FLAG), .SHIFT_FLAG(SHIFT_FLAG),
    .BUSY(BUSY), .FRAME_ERR(FRAME_ERR), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  // Returns {arith, logic, cmp, shift, result[15:0]}.
  function automatic logic [19:0] alu_eval(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic [3:0]  fl;
    case (f)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = 16'(a * b);
      4'd3:  r = (b == 16'd0) ? 16'd0 : a / b;
      4'd4:  r = a & b;
      4'd5:  r = a | b;
      4'd6:  r = ~(a & b);
      4'd7:  r = ~(a | b);
      4'd8:  r = a ^ b;
      4'd9:  r = ~(a ^ b);
      4'd10: r = (a == b) ? 16'd1 : 16'd0;
      4'd11: r = (a > b)  ? 16'd2 : 16'd0;
      4'd12: r = (a < b)  ? 16'd3 : 16'd0;
      4'd13: r = a >> 1;
      4'd14: r = a << 1;
      default: r = 16'd0;
    endcase
    if (f <= 4'd3)       fl = 4'b1000;
    else if (f <= 4'd9)  fl = 4'b0100;
    else if (f <= 4'd12) fl = 4'b0010;
    else                 fl = 4'b0001;
    return {fl, r};
  endfunction

  // ALU_16bit model: registered outputs, ALU_LAT edges deep, holds on NOP.
  logic [19:0] stg [ALU_LAT];
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int k = 0; k < ALU_LAT; k++) stg[k] <= '0;
    end else begin
      if (ALU_FUN != 4'hF) stg[0] <= alu_eval(ALU_FUN, ALU_A, ALU_B);
      for (int k = 1; k < ALU_LAT; k++) stg[k] <= stg[k-1];
    end
  end
  assign {ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG, ALU_OUT} = stg[ALU_LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    @(negedge CLK);
    RX_VALID = 1'b0;
  endtask

  // mode: 0 ready high, 1 random ready + gaps, 2 stall 5 cycles at SEND1, 3 overrun in SEND0
  task automatic run_frame(input logic [7:0] f, input logic [7:0] alo, input logic [7:0] ahi,
                           input logic [7:0] blo, input logic [7:0] bhi,
                           input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                           input int mode);
    logic [7:0]  fb [5];
    logic [7:0]  eb [3];
    logic [15:0] b_exp;
    int nb, cyc, i, g, stall;
    logic rdy;
    fb[0] = f; fb[1] = alo; fb[2] = ahi; fb[3] = blo; fb[4] = bhi;
    eb[0] = e0; eb[1] = e1; eb[2] = e2;
    nb = 5;
    b_exp = {bhi, blo};
`ifdef ALU_SHORT_FRAME_EN
    if (f == 8'h0D || f == 8'h0E) begin
      nb = 3;
      b_exp = last_b;
    end
`endif
    for (int k = 0; k < nb; k++) begin
      if (mode == 1) repeat ($urandom_range(0, 2)) @(negedge CLK);
      send_byte(fb[k]);
    end
    chk("busy_exec", 32'(BUSY), 32'd1);
    chk("alu_fun", 32'(ALU_FUN), 32'(f[3:0]));
    chk("alu_a", 32'(ALU_A), 32'({ahi, alo}));
    chk("alu_b", 32'(ALU_B), 32'(b_exp));
    cyc = 0;
    while (!TX_VALID && cyc < 50) begin
      @(negedge CLK);
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(ALU_LAT + 1));
    if (mode == 3) begin
      RX_DATA  = 8'hAA;
      RX_VALID = 1'b1;
      @(negedge CLK);
      RX_VALID = 1'b0;
      chk("overrun_pulse", 32'(OVERRUN), 32'd1);
      chk("overrun_tx", 32'(TX_DATA), 32'(e0));
      @(negedge CLK);
      chk("overrun_clear", 32'(OVERRUN), 32'd0);
    end
    i = 0; g = 0; stall = 0;
    while (i < 3 && g < 300) begin
      chk("tx_valid", 32'(TX_VALID), 32'd1);
      chk("tx_byte", 32'(TX_DATA), 32'(eb[i]));
      rdy = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 2 && i == 1 && stall < 5) begin
        rdy = 1'b0;
        stall++;
      end
      TX_READY = rdy;
      if (rdy) i++;
      @(negedge CLK);
      g++;
    end
    if (i < 3) chk("tx_timeout", 32'(i), 32'd3);
    TX_READY = 1'b0;
    chk("busy_done", 32'(BUSY), 32'd0);
    chk("tx_valid_done", 32'(TX_VALID), 32'd0);
    chk("alu_fun_nop", 32'(ALU_FUN), 32'hF);
    if (f[3:0] != 4'hF) ref_prev = alu_eval(f[3:0], {ahi, alo}, b_exp);
    last_b = b_exp;
  endtask

  task automatic chk_reset_vals();
    chk("rst_alu_a", 32'(ALU_A), 32'd0);
    chk("rst_alu_b", 32'(ALU_B), 32'd0);
    chk("rst_alu_fun", 32'(ALU_FUN), 32'hF);
    chk("rst_tx_data", 32'(TX_DATA), 32'd0);
    chk("rst_tx_valid", 32'(TX_VALID), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_frame_err", 32'(FRAME_ERR), 32'd0);
    chk("rst_overrun", 32'(OVERRUN), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  f;
    logic [15:0] a, b, bu;
    logic [19:0] e;
    RST = 1'b0; RX_DATA = 8'h00; RX_VALID = 1'b0; TX_READY = 1'b0;
    ref_prev = '0; last_b = '0;
    repeat (3) @(negedge CLK);
    chk_reset_vals();
    RST = 1'b1;
    @(negedge CLK);

    run_frame(8'h00, 8'h04, 8'h00, 8'h03, 8'h00, 8'h07, 8'h00, 8'h08, 0);
    run_frame(8'h09, 8'h07, 8'h00, 8'h06, 8'h00, 8'hFE, 8'hFF, 8'h04, 1);
    run_frame(8'h0B, 8'h07, 8'h00, 8'h06, 8'h00, 8'h02, 8'h00, 8'h02, 0);
    run_frame(8'h01, 8'h04, 8'h00, 8'h03, 8'h00, 8'h01, 8'h00, 8'h08, 2);
    run_frame(8'h00, 8'h04, 8'h00, 8'h03, 8'h00, 8'h07, 8'h00, 8'h08, 3);

    send_byte(8'h1F);
    chk("frame_err_pulse", 32'(FRAME_ERR), 32'd1);
    chk("frame_err_idle", 32'(BUSY), 32'd0);
    @(negedge CLK);
    chk("frame_err_clear", 32'(FRAME_ERR), 32'd0);
    run_frame(8'h0B, 8'h07, 8'h00, 8'h06, 8'h00, 8'h02, 8'h00, 8'h02, 0);
    // NOP returns the ALU's held outputs from the GT frame above
    run_frame(8'h0F, 8'h11, 8'h22, 8'h33, 8'h44, 8'h02, 8'h00, 8'h02, 0);

    send_byte(8'h00);
    send_byte(8'h04);
    send_byte(8'h00);
    RST = 1'b0;
    #1;
    chk_reset_vals();
    @(negedge CLK);
    RST = 1'b1;
    ref_prev = '0; last_b = '0;
    @(negedge CLK);
    run_frame(8'h0E, 8'h07, 8'h00, 8'h00, 8'h00, 8'h0E, 8'h00, 8'h01, 0);

`ifdef ALU_SHORT_FRAME_EN
    run_frame(8'h00, 8'h01, 8'h00, 8'h05, 8'h00, 8'h06, 8'h00, 8'h08, 0);
    run_frame(8'h0D, 8'h07, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h01, 0);
`endif

    for (int n = 0; n < 30; n++) begin
      f = 4'($urandom_range(0, 15));
      a = 16'($urandom);
      b = 16'($urandom);
      if (n % 4 == 0) begin
        a = 16'($urandom_range(0, 20));
        b = 16'($urandom_range(0, 20));
      end
      bu = b;
`ifdef ALU_SHORT_FRAME_EN
      if (f == 4'd13 || f == 4'd14) bu = last_b;
`endif
      e = (f == 4'hF) ? ref_prev : alu_eval(f, a, bu);
      run_frame({4'h0, f}, a[7:0], a[15:8], b[7:0], b[15:8],
                e[7:0], e[15:8], {4'h0, e[19:16]}, int'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
